// File: rtl/draw_pkg.sv
// Shared types for the frame draw controller: FSM state encoding and
// framebuffer coordinate types.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WAIT_SEG = 3'd2,
        LAUNCH   = 3'd3,
        DRAW     = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    // A frame is in flight in every state except IDLE and DONE.
    function automatic logic is_busy(state_t s);
        return !((s == IDLE) || (s == DONE));
    endfunction

endpackage

// File: rtl/draw_controller_if.sv
// Segment source, line engine and framebuffer write-port bundle.
// master = draw controller side, slave = segment source / line engine / framebuffer side.
interface draw_controller_if;
    import draw_pkg::*;

    // segment source handshake
    logic    seg_valid;
    logic    seg_ready;
    xcoord_t seg_x0, seg_x1;
    ycoord_t seg_y0, seg_y1;
    logic    seg_last;

    // line engine
    logic    line_start;
    logic    line_abort;
    xcoord_t line_x0, line_x1;
    ycoord_t line_y0, line_y1;
    logic    line_pix_valid;
    xcoord_t line_px;
    ycoord_t line_py;
    logic    line_done;

    // framebuffer write port
    xcoord_t pix_x;
    ycoord_t pix_y;
    logic    pix_color;
    logic    pix_we;

    modport master (
        input  seg_valid, seg_x0, seg_x1, seg_y0, seg_y1, seg_last,
        output seg_ready,
        output line_start, line_abort, line_x0, line_x1, line_y0, line_y1,
        input  line_pix_valid, line_px, line_py, line_done,
        output pix_x, pix_y, pix_color, pix_we
    );

    modport slave (
        output seg_valid, seg_x0, seg_x1, seg_y0, seg_y1, seg_last,
        input  seg_ready,
        input  line_start, line_abort, line_x0, line_x1, line_y0, line_y1,
        output line_pix_valid, line_px, line_py, line_done,
        input  pix_x, pix_y, pix_color, pix_we
    );

endinterface

// File: rtl/draw_controller_clear_sweep.sv
// Full-screen clear address generator: y is the inner index, x the outer.
// clr holds the counters at (0,0); en advances one pixel per cycle.
// last flags the final pixel (W-1,H-1); advancing past it returns to (0,0).
module clear_sweep
    import draw_pkg::*;
#(
    parameter int W = 640,
    parameter int H = 480
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clr,
    input  logic    en,
    output xcoord_t x,
    output ycoord_t y,
    output logic    last
);
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign last = (x_q == X_MAX) && (y_q == Y_MAX);
    assign x    = xcoord_t'(x_q);
    assign y    = ycoord_t'(y_q);

    // next address: y counts fastest, x steps only when y rolls over
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (y_q == Y_MAX) begin
                y_d = '0;
                x_d = last ? '0 : x_q + 1'b1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/draw_controller.sv
// Frame draw sequencer: clear sweep, then segments handed one at a time to
// the line engine. Owns the framebuffer write port (all outputs registered).
// Optional feature macro: DRAW_CTRL_CLIP_EN drops off-screen segments and
// counts them on clip_cnt.
module draw_controller
    import draw_pkg::*;
#(
    parameter int   SCREEN_W   = 640,
    parameter int   SCREEN_H   = 480,
    parameter logic CLR_COLOR  = 1'b0,
    parameter logic DRAW_COLOR = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic skip_clear,
    input  logic abort,
    draw_controller_if.master bus,
    output logic busy,
    output logic done
`ifdef DRAW_CTRL_CLIP_EN
    ,
    output logic [7:0] clip_cnt
`endif
);
    state_t  state_q, state_d;
    logic    last_q, last_d;
    xcoord_t lx0_q, lx0_d, lx1_q, lx1_d;
    ycoord_t ly0_q, ly0_d, ly1_q, ly1_d;
    logic    line_start_q, line_start_d;
    logic    line_abort_q, line_abort_d;
    logic    seg_ready_q, seg_ready_d;
    xcoord_t pix_x_q, pix_x_d;
    ycoord_t pix_y_q, pix_y_d;
    logic    pix_color_q, pix_color_d;
    logic    pix_we_q, pix_we_d;
    logic    busy_q, busy_d;
    logic    done_q, done_d;
    logic    seg_out;
`ifdef DRAW_CTRL_CLIP_EN
    logic [7:0] clip_cnt_q, clip_cnt_d;
    assign clip_cnt = clip_cnt_q;
`endif

    xcoord_t sw_x;
    ycoord_t sw_y;
    logic    sw_last;

    clear_sweep #(.W(SCREEN_W), .H(SCREEN_H)) u_sweep (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != CLEAR),
        .en    (state_q == CLEAR),
        .x     (sw_x),
        .y     (sw_y),
        .last  (sw_last)
    );

    // off-screen test only matters when clipping is built in
`ifdef DRAW_CTRL_CLIP_EN
    assign seg_out = (int'(bus.seg_x0) >= SCREEN_W) || (int'(bus.seg_x1) >= SCREEN_W) ||
                     (int'(bus.seg_y0) >= SCREEN_H) || (int'(bus.seg_y1) >= SCREEN_H);
`else
    assign seg_out = 1'b0;
`endif

    // next-state and next-output logic; abort outranks every other event
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        lx0_d        = lx0_q;
        lx1_d        = lx1_q;
        ly0_d        = ly0_q;
        ly1_d        = ly1_q;
        line_start_d = 1'b0;
        line_abort_d = 1'b0;
        pix_we_d     = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_color_d  = pix_color_q;
`ifdef DRAW_CTRL_CLIP_EN
        clip_cnt_d   = clip_cnt_q;
`endif
        if (abort && is_busy(state_q)) begin
            state_d      = IDLE;
            line_abort_d = (state_q == LAUNCH) || (state_q == DRAW);
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = skip_clear ? WAIT_SEG : CLEAR;
`ifdef DRAW_CTRL_CLIP_EN
                        clip_cnt_d = '0;
`endif
                    end
                end
                CLEAR: begin
                    pix_we_d    = 1'b1;
                    pix_x_d     = sw_x;
                    pix_y_d     = sw_y;
                    pix_color_d = CLR_COLOR;
                    if (sw_last) state_d = WAIT_SEG;
                end
                WAIT_SEG: begin
                    if (bus.seg_valid) begin
                        last_d = bus.seg_last;
                        if (seg_out) begin
`ifdef DRAW_CTRL_CLIP_EN
                            if (clip_cnt_q != 8'hFF) clip_cnt_d = clip_cnt_q + 8'd1;
`endif
                            state_d = bus.seg_last ? DONE : WAIT_SEG;
                        end else begin
                            lx0_d        = bus.seg_x0;
                            lx1_d        = bus.seg_x1;
                            ly0_d        = bus.seg_y0;
                            ly1_d        = bus.seg_y1;
                            line_start_d = 1'b1;
                            state_d      = LAUNCH;
                        end
                    end
                end
                LAUNCH: state_d = DRAW;
                DRAW: begin
                    // a pixel arriving with line_done is still written
                    if (bus.line_pix_valid) begin
                        pix_we_d    = 1'b1;
                        pix_x_d     = bus.line_px;
                        pix_y_d     = bus.line_py;
                        pix_color_d = DRAW_COLOR;
                    end
                    if (bus.line_done) state_d = last_q ? DONE : WAIT_SEG;
                end
                default: state_d = IDLE;
            endcase
        end
        seg_ready_d = (state_d == WAIT_SEG);
        busy_d      = is_busy(state_d);
        done_d      = (state_d == DONE);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b0;
            lx0_q        <= '0;
            lx1_q        <= '0;
            ly0_q        <= '0;
            ly1_q        <= '0;
            line_start_q <= 1'b0;
            line_abort_q <= 1'b0;
            seg_ready_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_color_q  <= 1'b0;
            pix_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DRAW_CTRL_CLIP_EN
            clip_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            lx0_q        <= lx0_d;
            lx1_q        <= lx1_d;
            ly0_q        <= ly0_d;
            ly1_q        <= ly1_d;
            line_start_q <= line_start_d;
            line_abort_q <= line_abort_d;
            seg_ready_q  <= seg_ready_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_color_q  <= pix_color_d;
            pix_we_q     <= pix_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DRAW_CTRL_CLIP_EN
            clip_cnt_q   <= clip_cnt_d;
`endif
        end
    end

    assign bus.seg_ready  = seg_ready_q;
    assign bus.line_start = line_start_q;
    assign bus.line_abort = line_abort_q;
    assign bus.line_x0    = lx0_q;
    assign bus.line_x1    = lx1_q;
    assign bus.line_y0    = ly0_q;
    assign bus.line_y1    = ly1_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_color  = pix_color_q;
    assign bus.pix_we     = pix_we_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
